// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// State encoding, default memory size and byte extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2
    } lsu_state_e;

    localparam int MEM_BYTES_DEF = 512;

    function automatic logic [15:0] ext_byte(
        input logic [7:0] b,
        input logic       sgn
    );
        return {{8{b[7] & sgn}}, b};
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM request and writeback response bundle of the LSU.
// master = pipeline side, slave = LSU.
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [RD_W-1:0]   resp_rd;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_byte, req_signed,
        output req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_signed,
        input  req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_err
    );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Merges captured load bytes and applies byte-load extension.
// Purely combinational; fed by the top-level capture register.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              hi_i,
    input  logic              byte_i,
    input  logic              sgn_i,
    input  logic [7:0]        lo_i,
    input  logic [DATA_W-1:0] dm_i,
    output logic [DATA_W-1:0] rdata_o
);

    always_comb begin
        rdata_o = dm_i;
        unique case (1'b1)
            byte_i:  rdata_o = ext_byte(dm_i[7:0], sgn_i);
            hi_i:    rdata_o = {dm_i[7:0], lo_i};
            default: rdata_o = dm_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: range check, misaligned split,
// DataMemory sequencing and single-pulse writeback response.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int RD_W      = 3,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_stage_lsu_if.slave    lsu_if,
    output logic              dm_enable,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_data_in,
    output logic              dm_MemWrite,
    output logic              dm_MemRead,
    output logic              dm_byte_enable,
    input  logic [DATA_W-1:0] dm_data_out
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] ONE_X = (ADDR_W+1)'(1);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RD_W-1:0]   rd_q;
    logic              we_q;
    logic              byte_q;
    logic              sgn_q;
    logic              split_q;
    logic [7:0]        lo_q;

    logic              dm_enable_q;
    logic [ADDR_W-1:0] dm_address_q;
    logic [DATA_W-1:0] dm_data_in_q;
    logic              dm_we_q;
    logic              dm_re_q;
    logic              dm_byte_q;

    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [RD_W-1:0]   resp_rd_q;
    logic              resp_err_q;

    logic [ADDR_W:0]   addr_x;
    logic              misal;
    logic              range_err;
    logic              req_err;
    logic              split_d;
    logic              narrow_d;
    logic [DATA_W-1:0] ld_data;

    assign lsu_if.req_ready = (state_q == IDLE);

    // Extra MSB keeps addr+1 from wrapping during the range check.
    assign addr_x    = {1'b0, lsu_if.req_addr};
    assign misal     = !lsu_if.req_byte && lsu_if.req_addr[0];
    assign range_err = (addr_x >= LIMIT)
                    || (!lsu_if.req_byte && (addr_x + ONE_X >= LIMIT));
    assign req_err   = range_err || (misal && !SPLIT_EN);
    assign split_d   = misal && SPLIT_EN;
    assign narrow_d  = lsu_if.req_byte || split_d;

    lsu_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .hi_i    (state_q == ACC_HI),
        .byte_i  (byte_q),
        .sgn_i   (sgn_q),
        .lo_i    (lo_q),
        .dm_i    (dm_data_out),
        .rdata_o (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            sgn_q        <= 1'b0;
            split_q      <= 1'b0;
            lo_q         <= '0;
            dm_enable_q  <= 1'b0;
            dm_address_q <= '0;
            dm_data_in_q <= '0;
            dm_we_q      <= 1'b0;
            dm_re_q      <= 1'b0;
            dm_byte_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            dm_enable_q  <= 1'b0;
            dm_address_q <= '0;
            dm_data_in_q <= '0;
            dm_we_q      <= 1'b0;
            dm_re_q      <= 1'b0;
            dm_byte_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lsu_if.req_valid && req_err) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rd_q    <= lsu_if.req_rd;
                    end else if (lsu_if.req_valid) begin
                        addr_q       <= lsu_if.req_addr;
                        wdata_q      <= lsu_if.req_wdata;
                        rd_q         <= lsu_if.req_rd;
                        we_q         <= lsu_if.req_we;
                        byte_q       <= lsu_if.req_byte;
                        sgn_q        <= lsu_if.req_signed;
                        split_q      <= split_d;
                        dm_enable_q  <= 1'b1;
                        dm_address_q <= lsu_if.req_addr;
                        dm_data_in_q <= narrow_d
                            ? {{(DATA_W-8){1'b0}}, lsu_if.req_wdata[7:0]}
                            : lsu_if.req_wdata;
                        dm_we_q      <= lsu_if.req_we;
                        dm_re_q      <= !lsu_if.req_we;
                        dm_byte_q    <= narrow_d;
                        state_q      <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    lo_q <= dm_data_out[7:0];
                    if (split_q) begin
                        dm_enable_q  <= 1'b1;
                        dm_address_q <= addr_q + ADDR_W'(1);
                        dm_data_in_q <= {{(DATA_W-8){1'b0}}, wdata_q[15:8]};
                        dm_we_q      <= we_q;
                        dm_re_q      <= !we_q;
                        dm_byte_q    <= 1'b1;
                        state_q      <= ACC_HI;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rd_q    <= rd_q;
                        resp_rdata_q <= we_q ? '0 : ld_data;
                        state_q      <= IDLE;
                    end
                end
                ACC_HI: begin
                    resp_valid_q <= 1'b1;
                    resp_rd_q    <= rd_q;
                    resp_rdata_q <= we_q ? '0 : ld_data;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_enable         = dm_enable_q;
    assign dm_address        = dm_address_q;
    assign dm_data_in        = dm_data_in_q;
    assign dm_MemWrite       = dm_we_q;
    assign dm_MemRead        = dm_re_q;
    assign dm_byte_enable    = dm_byte_q;
    assign lsu_if.resp_valid = resp_valid_q;
    assign lsu_if.resp_rdata = resp_rdata_q;
    assign lsu_if.resp_rd    = resp_rd_q;
    assign lsu_if.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: DataMemory model, vector table,
// directed multi-cycle sequences and a randomized reference model.
module tb_mem_stage_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.ADDR_W(16), .DATA_W(16), .RD_W(3)) bus ();

    logic        dm_enable;
    logic [15:0] dm_address;
    logic [15:0] dm_data_in;
    logic        dm_MemWrite;
    logic        dm_MemRead;
    logic        dm_byte_enable;
    logic [15:0] dm_data_out;

    mem_stage_lsu #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_BYTES (512),
        .RD_W      (3),
        .SPLIT_EN  (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_if         (bus),
        .dm_enable      (dm_enable),
        .dm_address     (dm_address),
        .dm_data_in     (dm_data_in),
        .dm_MemWrite    (dm_MemWrite),
        .dm_MemRead     (dm_MemRead),
        .dm_byte_enable (dm_byte_enable),
        .dm_data_out    (dm_data_out)
    );

    logic [7:0] mem [512];
    logic [7:0] ref_mem [512];
    int vectors = 0;
    int miscompares = 0;
    int dm_cnt = 0;

    // DataMemory: combinational read, write on rising edge.
    always_comb begin
        dm_data_out = 16'h0000;
        if (dm_enable && dm_MemRead) begin
            if (dm_byte_enable)
                dm_data_out = {8'h00, mem[dm_address[8:0]]};
            else
                dm_data_out = {mem[dm_address[8:0] + 9'd1],
                               mem[dm_address[8:0]]};
        end
    end

    always @(posedge clk) begin
        if (dm_enable && dm_MemWrite) begin
            mem[dm_address[8:0]] <= dm_data_in[7:0];
            if (!dm_byte_enable)
                mem[dm_address[8:0] + 9'd1] <= dm_data_in[15:8];
        end
        if (dm_enable)
            dm_cnt <= dm_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (!bus.resp_valid && (bus.resp_rdata != 0
                || bus.resp_rd != 0 || bus.resp_err)) begin
                miscompares++;
                $display("FAIL idle_resp_zero: got %h/%h/%b required 0",
                         bus.resp_rdata, bus.resp_rd, bus.resp_err);
            end
            if (dm_enable && dm_address >= 16'd512) begin
                miscompares++;
                $display("FAIL dm_addr_range: got %h required < 0200",
                         dm_address);
            end
        end
    end

    typedef struct {
        bit          we;
        bit          bt;
        bit          sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  rd;
        bit          err;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input bit e, input logic [15:0] d,
                                       input logic [2:0] r, input int l,
                                       input int c);
        logic [7:0] l8;
        logic [7:0] c8;
        l8 = 8'(l);
        c8 = 8'(c);
        return {33'd0, e, d, r, l8, c8};
    endfunction

    // Reference: byte-addressed array, rules computed directly.
    task automatic model(input bit we, input bit bt, input bit sgn,
                         input logic [15:0] a, input logic [15:0] wd,
                         output bit err, output logic [15:0] rdata,
                         output int lat, output int dmc);
        int ai;
        bit split;
        ai = int'(a);
        rdata = 16'h0000;
        err = (ai >= 512) || (!bt && ai + 1 >= 512);
        if (err) begin
            lat = 1;
            dmc = 0;
            return;
        end
        split = !bt && (ai % 2 == 1);
        lat = split ? 3 : 2;
        dmc = split ? 2 : 1;
        if (we) begin
            ref_mem[ai] = wd[7:0];
            if (!bt) ref_mem[ai+1] = wd[15:8];
        end else if (bt) begin
            rdata = sgn ? 16'($signed(ref_mem[ai])) : {8'h00, ref_mem[ai]};
        end else begin
            rdata = {ref_mem[ai+1], ref_mem[ai]};
        end
    endtask

    task automatic set_req(input bit we, input bit bt, input bit sgn,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [2:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_byte   = bt;
        bus.req_signed = sgn;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
    endtask

    task automatic run_req(input bit we, input bit bt, input bit sgn,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [2:0] rd,
                           output logic [63:0] got);
        int pre;
        int n;
        int lat;
        @(negedge clk);
        set_req(we, bt, sgn, a, wd, rd);
        pre = dm_cnt;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) lat = -1;
        got = pk(bus.resp_err, bus.resp_rdata, bus.resp_rd, lat,
                 dm_cnt - pre);
    endtask

    task automatic run_model(input bit we, input bit bt, input bit sgn,
                             input logic [15:0] a, input logic [15:0] wd,
                             input logic [2:0] rd, input string nm);
        logic [63:0] got;
        bit e;
        logic [15:0] d;
        int l;
        int c;
        model(we, bt, sgn, a, wd, e, d, l, c);
        run_req(we, bt, sgn, a, wd, rd, got);
        check(nm, got, pk(e, d, rd, l, c));
    endtask

    function automatic logic [57:0] outs();
        return {bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.resp_err,
                dm_enable, dm_address, dm_data_in, dm_MemWrite,
                dm_MemRead, dm_byte_enable, bus.req_ready};
    endfunction

    initial begin
        logic [63:0] got;
        logic [15:0] ea;
        logic [15:0] eb;
        bit e;
        int l;
        int c;
        int late;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0;
        bus.req_wdata  = 16'h0;
        bus.req_rd     = 3'd0;

        #3;
        check("reset_outputs", 64'(outs()), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 64'(outs()), 64'd1);

        for (int a = 0; a < 512; a += 2) begin
            logic [15:0] a16;
            a16 = 16'(a);
            run_model(1'b1, 1'b0, 1'b0, a16,
                      {a16[7:0] ^ 8'hA5, a16[7:0]}, 3'(a), "fill");
        end

        tbl[0]  = '{1, 0, 0, 16'h0010, 16'hABCD, 3'd1, 0, 16'h0000, 2};
        tbl[1]  = '{0, 0, 0, 16'h0010, 16'h0000, 3'd2, 0, 16'hABCD, 2};
        tbl[2]  = '{1, 1, 0, 16'h0020, 16'h55EF, 3'd3, 0, 16'h0000, 2};
        tbl[3]  = '{0, 1, 1, 16'h0020, 16'h0000, 3'd4, 0, 16'hFFEF, 2};
        tbl[4]  = '{0, 1, 0, 16'h0020, 16'h0000, 3'd5, 0, 16'h00EF, 2};
        tbl[5]  = '{0, 0, 0, 16'h0020, 16'h0000, 3'd6, 0, 16'h85EF, 2};
        tbl[6]  = '{1, 0, 0, 16'h0031, 16'h1234, 3'd7, 0, 16'h0000, 3};
        tbl[7]  = '{0, 1, 0, 16'h0031, 16'h0000, 3'd0, 0, 16'h0034, 2};
        tbl[8]  = '{0, 1, 1, 16'h0032, 16'h0000, 3'd1, 0, 16'h0012, 2};
        tbl[9]  = '{0, 0, 0, 16'h0031, 16'h0000, 3'd2, 0, 16'h1234, 3};
        tbl[10] = '{0, 0, 0, 16'h0200, 16'h0000, 3'd3, 1, 16'h0000, 1};
        tbl[11] = '{0, 1, 0, 16'h0200, 16'h0000, 3'd4, 1, 16'h0000, 1};
        tbl[12] = '{0, 0, 0, 16'h01FF, 16'h0000, 3'd5, 1, 16'h0000, 1};
        tbl[13] = '{1, 0, 0, 16'h01FF, 16'hDEAD, 3'd6, 1, 16'h0000, 1};
        tbl[14] = '{0, 1, 1, 16'h01FF, 16'h0000, 3'd7, 0, 16'h005B, 2};
        tbl[15] = '{0, 0, 0, 16'hFFFF, 16'h0000, 3'd0, 1, 16'h0000, 1};

        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            model(tbl[i].we, tbl[i].bt, tbl[i].sgn, tbl[i].addr,
                  tbl[i].wdata, e, d, l, c);
            run_req(tbl[i].we, tbl[i].bt, tbl[i].sgn, tbl[i].addr,
                    tbl[i].wdata, tbl[i].rd, got);
            check($sformatf("table[%0d]", i), got,
                  pk(tbl[i].err, tbl[i].rdata, tbl[i].rd, tbl[i].lat,
                     tbl[i].err ? 0 : tbl[i].lat - 1));
        end

        // Back-to-back with req_valid held high.
        model(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, e, ea, l, c);
        model(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, e, eb, l, c);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 3'd5);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 3'd6);
        check("b2b_busy_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("b2b_first_resp",
              {44'd0, bus.resp_valid, bus.resp_rdata, bus.resp_rd},
              {44'd0, 1'b1, ea, 3'd5});
        check("b2b_ready_in_resp", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_gap", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        check("b2b_second_resp",
              {44'd0, bus.resp_valid, bus.resp_rdata, bus.resp_rd},
              {44'd0, 1'b1, eb, 3'd6});

        // Reset during the high half of a split store.
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 16'h0041, 16'h9876, 3'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("split_hi_addr", 64'({dm_enable, dm_address}),
              64'({1'b1, 16'h0042}));
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'(outs()), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[9'h041] = 8'h76;
        late = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) late++;
        end
        check("dropped_resp", 64'(late), 64'd0);
        check("ready_after_reset", 64'(bus.req_ready), 64'd1);
        run_model(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0, 3'd3, "mem42_kept");
        run_model(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0, 3'd4, "mem41_lo");

        for (int i = 0; i < 300; i++) begin
            run_model(1'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom_range(0, 16'h210)), 16'($urandom),
                      3'($urandom), $sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
